uart_tx_param: RTL and testbench
================================

Name: uart_tx_param

Overview:
Parametrised successor to the single-byte UART transmitter. Configurable data width, parity mode and stop-bit count, with an internal FIFO behind a valid/ready handshake so back-to-back frames go out with no idle gap. Sits between any byte/word producer and the board TX pin. Bit period is exactly CLK_FREQUENCY/BAUD_RATE cycles.

Parameters:
CLK_FREQUENCY, 100_000_000, input clock frequency in Hz
BAUD_RATE, 19_200, line rate; BIT_TICKS = CLK_FREQUENCY/BAUD_RATE (integer divide)
DATA_BITS, 8, data bits per frame, legal range 5..9
PARITY_MODE, 1, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, FIFO entries; power of two, at least 2

Ports:
clk  in  1  clock; all logic on the rising edge
rst_n  in  1  asynchronous, active-low reset
din  in  DATA_BITS  word to transmit
din_valid  in  1  producer has a word on din
din_ready  out  1  FIFO can accept; transfer happens when din_valid and din_ready are both high at a rising edge
tx_out  out  1  serial line; registered; idles high
busy  out  1  high while the FSM is not IDLE or the FIFO is non-empty
fifo_count  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (asserted asynchronously, released synchronously to clk):
  - tx_out = 1, busy = 0, din_ready = 1, fifo_count = 0.
  - FIFO is flushed, FSM goes to IDLE, timers clear.
- Reset mid-frame aborts the frame immediately; the line returns high without completing the frame.
- din_ready = !full. It does not account for a pop in the same cycle.
- A push when full cannot occur. A pop when empty never occurs.
- Simultaneous push and pop leave fifo_count unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP (plus BREAK when the optional feature is enabled).
- IDLE:
  - If the FIFO is non-empty, pop the head into the shift register, compute parity, go to START.
  - tx_out goes low on the same edge.
  - Latency: a word accepted at edge T into an empty FIFO with the FSM idle produces the start bit falling at edge T+1.
- Each state holds its bit for exactly BIT_TICKS cycles. The tick counter clears on every state or bit change.
- DATA:
  - Sends DATA_BITS bits, LSB first, via a bit counter 0..DATA_BITS-1.
  - Advances to PARITY, or to STOP when PARITY_MODE = 0.
- PARITY bit value:
  - Odd mode: ~^data.
  - Even mode: ^data.
  - Computed on the word latched at pop, never on live din.
- STOP:
  - Holds tx_out high for STOP_BITS bit times.
  - On the final tick, if the FIFO is non-empty, pop and go directly to START (no idle cycle); otherwise go to IDLE.
- busy falls on the cycle the FSM enters IDLE with the FIFO empty.
- Elaboration fails ($error) if any of these hold:
  - DATA_BITS outside 5..9
  - STOP_BITS not 1 or 2
  - PARITY_MODE > 2
  - FIFO_DEPTH not a power of two
  - BIT_TICKS < 2

Optional Feature:
UART_TX_BREAK_EN
- Defined:
  - Adds input port send_break (1 bit) and state BREAK.
  - In IDLE, or at the final STOP tick, send_break = 1 takes priority over pending FIFO data.
  - tx_out is held low for FRAME_BITS*BIT_TICKS cycles, where FRAME_BITS = 1 + DATA_BITS + (PARITY_MODE != 0) + STOP_BITS.
  - The FSM then enters STOP for a mandatory STOP_BITS high period, then resumes normal operation.
  - The FIFO keeps accepting during BREAK. busy is high during BREAK.
- Undefined: no port and no state; behaviour as above.

Decomposition:
- Package uart_pkg holds:
  - parity_t enum: PARITY_NONE = 0, PARITY_ODD = 1, PARITY_EVEN = 2
  - tx_state_t enum
  - function frame_bits(data_bits, parity, stop_bits)
- One sub-module, uart_tx_fifo:
  - Synchronous FIFO with pointer wrap at FIFO_DEPTH and an occupancy counter.
  - Parameters WIDTH and DEPTH; same clk/rst_n.

Test Plan:
All tests use CLK_FREQUENCY = 100_000_000 and BAUD_RATE = 10_000_000, so BIT_TICKS = 10.
- Single word, 8 data bits, odd parity, 1 stop: push 0xA5. tx_out falls 1 cycle after acceptance. Bits 1,0,1,0,0,1,0,1 at 10 cycles each, parity 1, stop 1. Frame is 110 cycles; busy drops the cycle after.
- Burst, FIFO_DEPTH = 4: din_valid held high with 0x01..0x06. din_ready drops when fifo_count = 4. All six frames go out back-to-back with no high gap beyond the stop bit, in order.
- 7 data bits, no parity, 2 stop bits: push 0x7F. Frame is 100 cycles; tx_out is high for the final 20.
- 8 data bits, even parity: 0x03 gives parity bit 0; 0x07 gives parity bit 1.
- Reset mid-frame: rst_n low during data bit 3 with 2 words queued. tx_out = 1 and fifo_count = 0 without waiting for a clock edge. After release, a push of 0x5A transmits normally.
- UART_TX_BREAK_EN, 8 data bits, even parity, 1 stop: send_break in IDLE with 0x33 queued. Line is low for 110 cycles, then high for 10, then the 0x33 frame is sent.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART transmitter.
// UART_TX_BREAK_EN adds the BREAK state to tx_state_t.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_ODD  = 2'd1,
    PARITY_EVEN = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
`ifdef UART_TX_BREAK_EN
    , BREAK = 3'd5
`endif
  } tx_state_t;

  function automatic int frame_bits(
    input int data_bits,
    input int parity,
    input int stop_bits
  );
    return 1 + data_bits
      + ((parity != int'(PARITY_NONE)) ? 1 : 0)
      + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO feeding the UART transmitter.
// DEPTH is a power of two so the pointers wrap naturally.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wrData,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdData,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;

  assign rdData = mem[rdPtr];
  assign full   = count == CW'(DEPTH);
  assign empty  = count == '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wrPtr] <= wrData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + AW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with input FIFO.
// Define UART_TX_BREAK_EN to add send_break and the BREAK state.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 19_200,
  parameter int DATA_BITS     = 8,
  parameter int PARITY_MODE   = 1,
  parameter int STOP_BITS     = 1,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
`ifdef UART_TX_BREAK_EN
  input  logic                            send_break,
`endif
  input  logic [DATA_BITS-1:0]            din,
  input  logic                            din_valid,
  output logic                            din_ready,
  output logic                            tx_out,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int BIT_TICKS  = CLK_FREQUENCY / BAUD_RATE;
  localparam int FRAME_BITS =
    frame_bits(DATA_BITS, PARITY_MODE, STOP_BITS);
  localparam int TICK_W =
    (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam int IDX_W = $clog2(FRAME_BITS + 1);
  localparam bit HAS_PAR =
    PARITY_MODE != int'(PARITY_NONE);
  localparam bit ODD_PAR =
    PARITY_MODE == int'(PARITY_ODD);

  localparam logic [TICK_W-1:0] TICK_LAST =
    TICK_W'(BIT_TICKS - 1);
  localparam logic [IDX_W-1:0] DATA_LAST =
    IDX_W'(DATA_BITS - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);
`ifdef UART_TX_BREAK_EN
  localparam logic [IDX_W-1:0] FRAME_LAST =
    IDX_W'(FRAME_BITS - 1);
`endif

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : gBadData
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : gBadStop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : gBadPar
    $error("uart_tx_param: PARITY_MODE must be 0..2");
  end
  if (FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadDepth
    $error("uart_tx_param: FIFO_DEPTH must be 2^n");
  end
  if (BIT_TICKS < 2) begin : gBadTicks
    $error("uart_tx_param: BIT_TICKS must be >= 2");
  end

  tx_state_t            state;
  tx_state_t            stateNxt;
  logic [TICK_W-1:0]    tickCnt;
  logic [TICK_W-1:0]    tickNxt;
  logic [IDX_W-1:0]     bitIdx;
  logic [IDX_W-1:0]     idxNxt;
  logic                 stopIdx;
  logic                 stopNxt;
  logic [DATA_BITS-1:0] shReg;
  logic [DATA_BITS-1:0] shNxt;
  logic                 parBit;
  logic                 parNxt;
  logic                 txReg;
  logic                 txNxt;
  logic                 bitEnd;
  logic                 headPar;
  logic                 doPush;
  logic                 doPop;
  logic                 fifoFull;
  logic                 fifoEmpty;
  logic [DATA_BITS-1:0] headData;

  assign din_ready = !fifoFull;
  assign doPush    = din_valid && !fifoFull;
  assign bitEnd    = tickCnt == TICK_LAST;
  assign headPar   = ODD_PAR ? ~^headData : ^headData;
  assign tx_out    = txReg;
  assign busy      = (state != IDLE) || !fifoEmpty;

  uart_tx_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) uFifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (doPush),
    .wrData(din),
    .pop   (doPop),
    .rdData(headData),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tickCnt <= '0;
      bitIdx  <= '0;
      stopIdx <= 1'b0;
      shReg   <= '0;
      parBit  <= 1'b0;
      txReg   <= 1'b1;
    end else begin
      state   <= stateNxt;
      tickCnt <= tickNxt;
      bitIdx  <= idxNxt;
      stopIdx <= stopNxt;
      shReg   <= shNxt;
      parBit  <= parNxt;
      txReg   <= txNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    tickNxt  = bitEnd ? '0 : tickCnt + TICK_W'(1);
    idxNxt   = bitIdx;
    stopNxt  = stopIdx;
    shNxt    = shReg;
    parNxt   = parBit;
    txNxt    = txReg;
    doPop    = 1'b0;
    unique case (state)
      IDLE: begin
        tickNxt = '0;
`ifdef UART_TX_BREAK_EN
        if (send_break) begin
          stateNxt = BREAK;
          idxNxt   = '0;
          txNxt    = 1'b0;
        end else
`endif
        if (!fifoEmpty) begin
          doPop    = 1'b1;
          shNxt    = headData;
          parNxt   = headPar;
          stateNxt = START;
          txNxt    = 1'b0;
        end
      end
      START: begin
        if (bitEnd) begin
          stateNxt = DATA;
          idxNxt   = '0;
          txNxt    = shReg[0];
        end
      end
      DATA: begin
        if (bitEnd) begin
          if (bitIdx != DATA_LAST) begin
            idxNxt = bitIdx + IDX_W'(1);
            shNxt  = shReg >> 1;
            txNxt  = shReg[1];
          end else if (HAS_PAR) begin
            stateNxt = PARITY;
            txNxt    = parBit;
          end else begin
            stateNxt = STOP;
            stopNxt  = 1'b0;
            txNxt    = 1'b1;
          end
        end
      end
      PARITY: begin
        if (bitEnd) begin
          stateNxt = STOP;
          stopNxt  = 1'b0;
          txNxt    = 1'b1;
        end
      end
      STOP: begin
        if (bitEnd) begin
          if (stopIdx != STOP_LAST) begin
            stopNxt = 1'b1;
          end else
`ifdef UART_TX_BREAK_EN
          if (send_break) begin
            stateNxt = BREAK;
            idxNxt   = '0;
            txNxt    = 1'b0;
          end else
`endif
          if (!fifoEmpty) begin
            // back-to-back: next start bit follows the stop bit directly
            doPop    = 1'b1;
            shNxt    = headData;
            parNxt   = headPar;
            stateNxt = START;
            txNxt    = 1'b0;
          end else begin
            stateNxt = IDLE;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      BREAK: begin
        if (bitEnd) begin
          if (bitIdx != FRAME_LAST) begin
            idxNxt = bitIdx + IDX_W'(1);
          end else begin
            stateNxt = STOP;
            idxNxt   = '0;
            stopNxt  = 1'b0;
            txNxt    = 1'b1;
          end
        end
      end
`endif
      default: begin
        stateNxt = IDLE;
        txNxt    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param at BIT_TICKS = 10.
// Define UART_TX_BREAK_EN to also exercise the break path.
module tb_uart_tx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [2:0][8:0] din;
  logic [2:0]      vld;
  wire  [2:0]      rdy;
  wire  [2:0]      tx;
  wire  [2:0]      bsy;
  wire  [2:0][2:0] cnt;
`ifdef UART_TX_BREAK_EN
  logic [2:0]      brk;
`endif

  int total = 0;
  int bad   = 0;

  // u0: 8 data, odd, 1 stop
  uart_tx_param #(
    .CLK_FREQUENCY(100_000_000), .BAUD_RATE(10_000_000),
    .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1),
    .FIFO_DEPTH(4)
  ) u0 (
    .clk(clk), .rst_n(rst_n),
`ifdef UART_TX_BREAK_EN
    .send_break(brk[0]),
`endif
    .din(din[0][7:0]), .din_valid(vld[0]),
    .din_ready(rdy[0]), .tx_out(tx[0]),
    .busy(bsy[0]), .fifo_count(cnt[0])
  );

  // u1: 7 data, no parity, 2 stop
  uart_tx_param #(
    .CLK_FREQUENCY(100_000_000), .BAUD_RATE(10_000_000),
    .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2),
    .FIFO_DEPTH(4)
  ) u1 (
    .clk(clk), .rst_n(rst_n),
`ifdef UART_TX_BREAK_EN
    .send_break(brk[1]),
`endif
    .din(din[1][6:0]), .din_valid(vld[1]),
    .din_ready(rdy[1]), .tx_out(tx[1]),
    .busy(bsy[1]), .fifo_count(cnt[1])
  );

  // u2: 8 data, even, 1 stop
  uart_tx_param #(
    .CLK_FREQUENCY(100_000_000), .BAUD_RATE(10_000_000),
    .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1),
    .FIFO_DEPTH(4)
  ) u2 (
    .clk(clk), .rst_n(rst_n),
`ifdef UART_TX_BREAK_EN
    .send_break(brk[2]),
`endif
    .din(din[2][7:0]), .din_valid(vld[2]),
    .din_ready(rdy[2]), .tx_out(tx[2]),
    .busy(bsy[2]), .fifo_count(cnt[2])
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // v[0] is the start bit; each bit is checked at its
  // first and tenth cycle, then the task steps to the next
  task automatic frame(
    input int          u,
    input logic [15:0] v,
    input int          n,
    input string       tag
  );
    chk({tag, "_bsy1"}, bsy[u], 1);
    for (int b = 0; b < n; b++) begin
      chk($sformatf("%s_b%0d_s", tag, b), tx[u], v[b]);
      repeat (9) tick;
      chk($sformatf("%s_b%0d_e", tag, b), tx[u], v[b]);
      tick;
    end
  endtask

  task automatic send(
    input int          u,
    input logic [8:0]  d,
    input logic [15:0] v,
    input int          n,
    input string       tag
  );
    din[u] = d;
    vld[u] = 1'b1;
    chk({tag, "_rdy"}, rdy[u], 1);
    tick;
    vld[u] = 1'b0;
    chk({tag, "_lat"}, tx[u], 1);
    chk({tag, "_cnt"}, cnt[u], 1);
    tick;
    frame(u, v, n, tag);
    chk({tag, "_bsy0"}, bsy[u], 0);
    chk({tag, "_idle"}, tx[u], 1);
  endtask

  // {stop, parity, data, start}: odd parity for 0x01..0x06
  logic [15:0] burstV [6];

  initial begin
    burstV[0] = 16'h0402;
    burstV[1] = 16'h0404;
    burstV[2] = 16'h0606;
    burstV[3] = 16'h0408;
    burstV[4] = 16'h060A;
    burstV[5] = 16'h060C;
    rst_n = 1'b0;
    din   = '0;
    vld   = '0;
`ifdef UART_TX_BREAK_EN
    brk   = '0;
`endif
    repeat (3) tick;
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("rst_tx%0d", u), tx[u], 1);
      chk($sformatf("rst_bsy%0d", u), bsy[u], 0);
      chk($sformatf("rst_rdy%0d", u), rdy[u], 1);
      chk($sformatf("rst_cnt%0d", u), cnt[u], 0);
    end
    rst_n = 1'b1;
    repeat (2) tick;

    send(0, 9'hA5, {5'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11, "a5");

    fork
      begin
        for (int w = 1; w <= 6; w++) begin
          din[0] = 9'(w);
          vld[0] = 1'b1;
          for (int g = 0; g < 400 && !rdy[0]; g++) tick;
          chk($sformatf("burst_rdy_w%0d", w), rdy[0], 1);
          tick;
          if (w == 5) begin
            chk("burst_cnt4", cnt[0], 4);
            chk("burst_rdy0", rdy[0], 0);
          end
        end
        vld[0] = 1'b0;
      end
      begin
        for (int g = 0; g < 20 && tx[0]; g++) tick;
        chk("burst_fall", tx[0], 0);
        for (int i = 0; i < 6; i++) begin
          frame(0, burstV[i], 11, $sformatf("burst%0d", i));
        end
      end
    join
    chk("burst_bsy0", bsy[0], 0);
    chk("burst_cnt0", cnt[0], 0);
    chk("burst_idle", tx[0], 1);

    send(1, 9'h7F, {6'b0, 2'b11, 7'h7F, 1'b0}, 10, "b7f");
    send(2, 9'h03, {5'b0, 1'b1, 1'b0, 8'h03, 1'b0}, 11, "c03");
    send(2, 9'h07, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, "c07");

    din[0] = 9'h11;
    vld[0] = 1'b1;
    tick;
    din[0] = 9'h22;
    tick;
    din[0] = 9'h33;
    tick;
    vld[0] = 1'b0;
    // middle of data bit 3 of the 0x11 frame
    repeat (44) tick;
    chk("mid_cnt", cnt[0], 2);
    chk("mid_tx", tx[0], 0);
    rst_n = 1'b0;
    #1;
    chk("arst_tx", tx[0], 1);
    chk("arst_cnt", cnt[0], 0);
    chk("arst_bsy", bsy[0], 0);
    chk("arst_rdy", rdy[0], 1);
    repeat (2) tick;
    rst_n = 1'b1;
    tick;
    chk("post_rst_tx", tx[0], 1);
    send(0, 9'h5A, {5'b0, 1'b1, 1'b1, 8'h5A, 1'b0}, 11, "p5a");

`ifdef UART_TX_BREAK_EN
    din[2] = 9'h33;
    vld[2] = 1'b1;
    brk[2] = 1'b1;
    tick;
    vld[2] = 1'b0;
    brk[2] = 1'b0;
    chk("brk_cnt", cnt[2], 1);
    frame(2, {4'b0, 1'b1, 11'b0}, 12, "brk");
    frame(2, {5'b0, 1'b1, 1'b0, 8'h33, 1'b0}, 11, "brk33");
    chk("brk_bsy0", bsy[2], 0);
    chk("brk_cnt0", cnt[2], 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
